// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock under a
// start/busy/done handshake, producing the signed 2*WIDTH-bit product a*b.
module booth_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned AW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   m_reg, m_next;
    logic [AW-1:0]   acc, acc_next, acc_sum;
    logic [WIDTH-1:0] q, q_next;
    logic            q1, q1_next;
    logic [CW-1:0]   count, count_next;
    logic [PW-1:0]   product_next;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Booth datapath step
    always_comb begin
        state_next   = state;
        m_next       = m_reg;
        acc_next     = acc;
        q_next       = q;
        q1_next      = q1;
        count_next   = count;
        product_next = product;
        acc_sum      = acc;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    m_next     = {a[WIDTH-1], a};
                    acc_next   = '0;
                    q_next     = b;
                    q1_next    = 1'b0;
                    count_next = CW'(WIDTH);
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                unique case ({q[0], q1})
                    2'b01:   acc_sum = acc + m_reg;
                    2'b10:   acc_sum = acc - m_reg;
                    default: acc_sum = acc;
                endcase
                // Arithmetic shift right of {acc, q, q1}; old q1 falls off
                {acc_next, q_next, q1_next} = {acc_sum[AW-1], acc_sum, q};
                count_next = count - CW'(1);
                if (count == CW'(1)) begin
                    product_next = {acc_next[WIDTH-1:0], q_next};
                    state_next   = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers; product only moves on entry to DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reg   <= '0;
            acc     <= '0;
            q       <= '0;
            q1      <= 1'b0;
            count   <= '0;
            product <= '0;
        end else begin
            m_reg   <= m_next;
            acc     <= acc_next;
            q       <= q_next;
            q1      <= q1_next;
            count   <= count_next;
            product <= product_next;
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier (WIDTH=8): reset, latency,
// signed corners, ignored start, held start and mid-calculation reset.
module tb_booth_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_checks;
    int n_fail;

    booth_multiplier #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns in the first CALC cycle
    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        step();
        start = 1'b0;
    endtask

    // Step until done (bounded); report cycles stepped and busy cycles seen
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cycles < 30) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) step();
        n_checks++;
        if ({busy, done, product} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_held: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
        end
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if ({busy, done, product} !== 18'h0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: busy=%b done=%b product=%h, want 0 0 0000", i, busy, done, product);
            end
        end
    endtask

    task automatic test_basic();
        int cyc, bc;
        launch(8'd3, 8'd5);
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles after first busy, want 8", cyc);
        end
        n_checks++;
        if (bc !== 8) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
        end
        n_checks++;
        if ({busy, done, product} !== {2'b01, 16'h000F}) begin
            n_fail++;
            $display("FAIL basic_done: busy=%b done=%b product=%h, want 0 1 000f", busy, done, product);
        end
        repeat (3) begin
            step();
            n_checks++;
            if ({busy, done, product} !== {2'b00, 16'h000F}) begin
                n_fail++;
                $display("FAIL basic_hold: busy=%b done=%b product=%h, want 0 0 000f", busy, done, product);
            end
        end
    endtask

    task automatic test_signed();
        logic [7:0]  va [4] = '{8'hF9, 8'h7F, 8'h80, 8'h00};
        logic [7:0]  vb [4] = '{8'h06, 8'h80, 8'h80, 8'hFF};
        logic [15:0] ve [4] = '{16'hFFD6, 16'hC080, 16'h4000, 16'h0000};
        int cyc, bc;
        for (int i = 0; i < 4; i++) begin
            launch(va[i], vb[i]);
            wait_done(cyc, bc);
            n_checks++;
            if (done !== 1'b1 || cyc !== 8 || product !== ve[i]) begin
                n_fail++;
                $display("FAIL signed[%0d]: done=%b cycles=%0d product=%h, want 1 8 %h", i, done, cyc, product, ve[i]);
            end
            step();
        end
    endtask

    task automatic test_ignore_start();
        int cyc, bc, extra_done;
        launch(8'd10, 8'd11);
        repeat (2) step();
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        step();
        start = 1'b0;
        step();
        start = 1'b1; a = 8'd50; b = 8'd50;
        step();
        start = 1'b0;
        wait_done(cyc, bc);
        n_checks++;
        if (done !== 1'b1 || cyc !== 3 || product !== 16'h006E) begin
            n_fail++;
            $display("FAIL ignore_start: done=%b cycles=%0d product=%h, want 1 3 006e", done, cyc, product);
        end
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        n_checks++;
        if (extra_done !== 0) begin
            n_fail++;
            $display("FAIL ignore_start_single_done: got %0d active cycles after done, want 0", extra_done);
        end
    endtask

    task automatic test_held_start();
        int ndone;
        logic exp_done;
        ndone = 0;
        start = 1'b1;
        a     = 8'd2;
        b     = 8'hFD;
        for (int i = 1; i <= 27; i++) begin
            step();
            exp_done = (i % 9 == 0);
            if (i == 27) start = 1'b0;
            if (done === 1'b1) ndone++;
            n_checks++;
            if (done !== exp_done || busy !== !exp_done ||
                (exp_done && product !== 16'hFFFA)) begin
                n_fail++;
                $display("FAIL held_start[%0d]: busy=%b done=%b product=%h, want %b %b fffa",
                         i, busy, done, product, !exp_done, exp_done);
            end
        end
        n_checks++;
        if (ndone !== 3) begin
            n_fail++;
            $display("FAIL held_start_count: got %0d dones, want 3", ndone);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int cyc, bc, stray;
        launch(8'd5, 8'd5);
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b1 || product !== 16'hFFFA) begin
            n_fail++;
            $display("FAIL mid_calc_hold: busy=%b product=%h, want 1 fffa", busy, product);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, product} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
        end
        step();
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1 || product !== 16'h0) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d active cycles after release, want 0", stray);
        end
        launch(8'd4, 8'd4);
        wait_done(cyc, bc);
        n_checks++;
        if (done !== 1'b1 || cyc !== 8 || product !== 16'h0010) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: done=%b cycles=%0d product=%h, want 1 8 0010", done, cyc, product);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_signed();
        test_ignore_start();
        test_held_start();
        test_reset_mid();
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Sequential radix-2 Booth multiplier that consumes the signed operands A and B latched by the number storage stage and produces their signed 2×WIDTH-bit product. It iterates one Booth step per clock under a start/busy/done handshake. The result feeds the result/display path downstream.

## Interface
- WIDTH, 8, operand width in bits (two's complement); product is 2*WIDTH bits
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request a multiplication; sampled only when not busy
- a  input  WIDTH  multiplicand (signed), captured on accepted start
- b  input  WIDTH  multiplier (signed), captured on accepted start
- busy  output  1  high while Booth iterations are in progress
- done  output  1  one-cycle pulse when product holds a new result
- product  output  2*WIDTH  signed product a*b, held until the next completion

## Operation
- States: IDLE, CALC, DONE.
- Internal registers: M (WIDTH+1, sign-extended a), Acc (WIDTH+1), Q (WIDTH), Q_1 (1), count (clog2(WIDTH+1)).
- IDLE/DONE with start=1: M <= sext(a), Acc <= 0, Q <= b, Q_1 <= 0, count <= WIDTH, go to CALC.
- IDLE/DONE with start=0: go to IDLE. start is edge-insensitive and level-sampled; a held start re-triggers each time the block becomes idle.
- CALC, each cycle, on {Q[0],Q_1}:
  - 00/11: no add
  - 01: Acc' = Acc + M
  - 10: Acc' = Acc - M
  - then arithmetic shift right of {Acc',Q,Q_1} by 1 (Acc MSB replicated); count <= count-1.
- CALC with count==1 (last step): product <= {Acc_new[WIDTH-1:0], Q_new}; go to DONE.
- start in CALC ignored; a/b changes in CALC have no effect.
- Arithmetic in WIDTH+1 bits, modulo 2^(WIDTH+1). The extra Acc bit makes -2^(WIDTH-1) × -2^(WIDTH-1) exact; no overflow is possible in the 2*WIDTH result.
- Reset (any state, including mid-CALC): state IDLE, all internal registers 0, busy=0, done=0, product=0. An in-flight operation is discarded.

## Timing
- Outputs are registered or decoded purely from state. busy = (state==CALC), done = (state==DONE).
- Start accepted at rising edge T. busy=1 for cycles T+1..T+WIDTH (WIDTH cycles). done=1 and product valid in cycle T+WIDTH+1.
- Latency from accepted start edge to done: WIDTH+1 cycles (9 for WIDTH=8).
- Back-to-back: start high during the DONE cycle is accepted. The next busy begins the following cycle. Throughput is one result per WIDTH+1 cycles.
- product changes only at the transition into DONE. It is stable from then until the next completion, including during the following CALC.
- done never asserts without a preceding accepted start. There is exactly one done per accepted start, unless reset intervenes.

## Test plan
- Reset release, no start → busy=0, done=0, product=16'h0000 indefinitely.
- a=3, b=5, start 1 cycle → busy for 8 cycles, done in the 9th cycle after the start edge, product=16'h000F, held afterward.
- Signed corners, each run separately: a=-7, b=6 → 16'hFFD6; a=127, b=-128 → 16'hC080; a=-128, b=-128 → 16'h4000; a=0, b=-1 → 16'h0000.
- start re-pulsed with different a/b at cycles 3 and 5 of CALC → ignored; exactly one done, with the original operands' product.
- start held high continuously, a=2, b=-3 → done every 9 cycles, each product 16'hFFFA, busy low only in the DONE cycle.
- rst asserted at CALC cycle 4 → immediately busy=0, done=0, product=0. After release, no done until a new start; a fresh 4×4 gives 16'h0010.
